// File: rtl/sha256_sweep_sched.sv
`default_nettype none
// ==========================================================================
// sha256_sweep_sched : sequences one looped sha256_transform through a nonce sweep
// Revision 1.0 - initial release
// ==========================================================================
module sha256_sweep_sched #(
  parameter int LOOP       = 4,
  parameter int MERGE      = 1,
  parameter int HASH_LAT   = 65,
  parameter int NONCE_WORD = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid_i,
  output logic         job_ready_o,
  input  logic [255:0] job_state_i,
  input  logic [511:0] job_data_i,
  input  logic [31:0]  job_nonce_start_i,
  input  logic [31:0]  job_nonce_end_i,
  input  logic [31:0]  job_target_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         hit_valid_o,
  input  logic         hit_ready_i,
  output logic [31:0]  hit_nonce_o,
  output logic         hit_overflow_o,
  output logic [5:0]   tf_cnt_o,
  output logic         tf_feedback_o,
  output logic [255:0] tf_state_o,
  output logic [511:0] tf_input_o,
  input  logic [255:0] tf_hash_i
);

  localparam int PW = (LOOP > 1) ? $clog2(LOOP) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [255:0]        mid_q, mid_d;
  logic [511:0]        data_q, data_d;
  logic [31:0]         nonce_q, nonce_d;
  logic [31:0]         target_q, target_d;
  logic [32:0]         count_q, count_d;
  logic [HASH_LAT-1:0] dlv_q, dlv_d;
  logic [31:0]         dln_q [HASH_LAT];
  logic                hv_q, hv_d;
  logic [31:0]         hn_q, hn_d;
  logic                ovf_q, ovf_d;

  logic accept;
  logic launch;
  logic flush;
  logic ev_hit;
  logic pop;
  logic unused_hash_bits;

  assign unused_hash_bits = ^tf_hash_i[223:0];

  // Phase counter runs regardless of the FSM so the transform's loop stays aligned.
  always_comb begin
    phase_d = (phase_q == PW'(LOOP - 1)) ? '0 : phase_q + 1'b1;
  end

  assign tf_cnt_o      = 6'(int'(phase_q) * MERGE);
  assign tf_feedback_o = (phase_q != '0);

  always_comb begin
    state_d  = state_q;
    mid_d    = mid_q;
    data_d   = data_q;
    nonce_d  = nonce_q;
    target_d = target_q;
    count_d  = count_q;
    accept   = 1'b0;
    launch   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_valid_i) begin
          accept   = 1'b1;
          mid_d    = job_state_i;
          data_d   = job_data_i;
          nonce_d  = job_nonce_start_i;
          target_d = job_target_i;
          count_d  = {1'b0, job_nonce_end_i - job_nonce_start_i} + 33'd1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (phase_q == '0) begin
          launch  = 1'b1;
          nonce_d = nonce_q + 32'd1;
          count_d = count_q - 33'd1;
          if (count_q == 33'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (dlv_q == '0) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush = abort_i && (state_q != IDLE);

  always_comb begin
    dlv_d = flush ? '0 : {dlv_q[HASH_LAT-2:0], launch};
  end

  // An entry leaving the delay line lines up with the transform's result for that launch.
  assign ev_hit = dlv_q[HASH_LAT-1] && (tf_hash_i[255:224] <= target_q) && !flush;
  assign pop    = hv_q && hit_ready_i;

  always_comb begin
    hv_d  = hv_q && !pop;
    hn_d  = hn_q;
    ovf_d = accept ? 1'b0 : ovf_q;
    if (ev_hit) begin
      if (!hv_q || pop) begin
        hv_d = 1'b1;
        hn_d = dln_q[HASH_LAT-1];
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      mid_q    <= '0;
      data_q   <= '0;
      nonce_q  <= '0;
      target_q <= '0;
      count_q  <= '0;
      dlv_q    <= '0;
      hv_q     <= 1'b0;
      hn_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      mid_q    <= mid_d;
      data_q   <= data_d;
      nonce_q  <= nonce_d;
      target_q <= target_d;
      count_q  <= count_d;
      dlv_q    <= dlv_d;
      hv_q     <= hv_d;
      hn_q     <= hn_d;
      ovf_q    <= ovf_d;
    end
  end

  // Nonce payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    dln_q[0] <= nonce_q;
    for (int i = 1; i < HASH_LAT; i++) begin
      dln_q[i] <= dln_q[i-1];
    end
  end

  always_comb begin
    tf_input_o = data_q;
    tf_input_o[NONCE_WORD*32 +: 32] = nonce_q;
  end

  assign tf_state_o     = mid_q;
  assign job_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign hit_valid_o    = hv_q;
  assign hit_nonce_o    = hn_q;
  assign hit_overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: doc/sha256_sweep_sched.md
Name: sha256_sweep_sched

Overview:
Controller that sequences one looped sha256_transform instance through a nonce sweep.
- Accepts a job: midstate, 512-bit data block, nonce range and target.
- Generates the transform's cnt/feedback phase sequence and launches one nonce per LOOP cycles.
- Tags every in-flight launch and compares each returned tx_hash against the target.
- Reports hits through a 1-deep valid/ready buffer and signals job completion after the pipe drains.

Parameters:
LOOP, 4, transform loop factor; must equal the transform's LOOP; power of 2 in 1..64
MERGE, 1, transform merge factor; must equal the transform's MERGE
HASH_LAT, 65, cycles from launch cycle to the cycle tx_hash holds that result; equals 64/MERGE+1
NONCE_WORD, 3, 32-bit word index of the nonce inside the data block, bits [NONCE_WORD*32 +: 32]

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
job_valid  in  1  job offer
job_ready  out  1  high only in IDLE
job_state  in  256  midstate for the job
job_data  in  512  data block; the nonce word is overwritten
job_nonce_start  in  32  first nonce
job_nonce_end  in  32  last nonce, inclusive
job_target  in  32  hit if tx_hash[255:224] <= target (unsigned)
abort  in  1  cancel the current job
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a sweep completes normally
hit_valid  out  1  hit buffer full
hit_ready  in  1  consumer accepts the hit
hit_nonce  out  32  nonce of the buffered hit
hit_overflow  out  1  sticky flag: a hit was dropped; cleared on job accept
tf_cnt  out  6  to transform cnt
tf_feedback  out  1  to transform feedback
tf_state  out  256  to transform rx_state
tf_input  out  512  to transform rx_input
tf_hash  in  256  from transform tx_hash

Behaviour:
- Reset values: state=IDLE; phase=0; job_ready=1; busy=0; done=0; hit_valid=0; hit_nonce=0; hit_overflow=0; all delay-line valid bits=0; job registers=0.
- Phase counter p:
  - Free-running 0..LOOP-1, wraps to 0, independent of FSM state.
  - tf_cnt = p*MERGE; tf_feedback = (p != 0).
  - LOOP=1 gives feedback=0 and cnt=0 every cycle.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: when job_valid && job_ready, register state, data, nonce_start, target and count = (end - start) mod 2^32 + 1, clear hit_overflow, go to RUN. end == start gives 1 nonce; end == start-1 gives the full 2^32 space, with a 33-bit counter.
  - RUN: a launch occurs in every cycle with p == 0. On each launch, push {1, nonce} into the delay line, then nonce <= nonce+1 (wraps 0xFFFFFFFF->0) and count <= count-1. After the launch that brings count to 0, go to DRAIN.
  - DRAIN: no launches. When no delay-line entry is valid and no result is being evaluated this cycle, pulse done for 1 cycle and go to IDLE.
- Launch data:
  - tf_input = job_data with word NONCE_WORD replaced by the current nonce register.
  - tf_state = job_state register. It is held constant from accept until return to IDLE, because the transform adds rx_state when tx_hash is captured.
  - Outside launch cycles tf_input still reflects the registers; the transform ignores it.
- Delay line:
  - HASH_LAT-deep shift of {valid, nonce}, shifting every cycle.
  - An entry pushed in cycle t is evaluated in cycle t+HASH_LAT against tf_hash sampled that cycle.
  - Hit = valid && tf_hash[255:224] <= target.
- Hit buffer:
  - Pop: hit_valid && hit_ready clears hit_valid at the next edge.
  - Hit while the buffer is empty, or being popped in the same cycle: load hit_nonce and set hit_valid.
  - Hit while the buffer is full and not being popped: drop the hit and set hit_overflow.
- Abort:
  - In RUN or DRAIN: next state IDLE, all delay-line valid bits cleared, no done pulse.
  - hit_valid already held is kept.
  - Stale hashes still leaving the transform are ignored.
  - In IDLE, abort has no effect.
  - Abort and job_valid in the same IDLE cycle: the job is accepted.
- reset mid-operation: all state returns to reset values at the next edge; in-flight results are ignored.
- done and job accept never coincide: done occurs in DRAIN, and job_ready rises the following cycle.

Test Plan:
All tests use a stub transform: registered model, tx_hash = f(rx_input) captured HASH_LAT cycles after a p==0 cycle, f programmable per nonce.
1. LOOP=4, start=10, end=12, target=0, f makes nonce 11 give top word 0 -> launches at p==0 spaced 4 cycles; hit_nonce=11; done exactly HASH_LAT cycles after the third launch (+1 for the DRAIN check); tf_state stable throughout.
2. start=0xFFFFFFFE, end=0x00000001 -> nonces FFFFFFFE, FFFFFFFF, 0, 1 are launched; exactly 4 launches.
3. start=end=5, target=0xFFFFFFFF -> a single launch; hit_nonce=5; one done pulse; hit_overflow=0.
4. Three consecutive hits with hit_ready=0 -> first hit held, hit_overflow=1; a new job accept clears hit_overflow.
5. abort 10 cycles after launch with hits pending in the pipe -> IDLE next cycle; no done pulse; no hit reported from that job; a following job runs cleanly.
6. reset asserted during RUN -> all outputs return to reset values at the next edge; a later result from the stub is not reported; tf_cnt restarts at 0.
